// File: rtl/ram_pkg.sv
// Shared constants for the 18 Kb block RAM and the logic that shares its ports.
package ram_pkg;

  localparam int RAM_REQ_ID_W = 1;
  localparam int RAM_ADDR_W   = 10;
  localparam int RAM_DATA_W   = 16;
  localparam int RAM_BURST_W  = 8;

  typedef logic [RAM_REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-input round-robin grant with bounded bursts. The current owner keeps the
// port while the other side waits until it has had BURST_MAX accepted beats.
module ram_arb_rr2
  import ram_pkg::*;
#(
  parameter int BURST_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  localparam logic [RAM_BURST_W-1:0] BURST_LIMIT = RAM_BURST_W'(BURST_MAX);

  req_id_t                owner_q, owner_d;
  logic [RAM_BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   burst_open;

  // Grant: a lone requester always wins; under contention the owner keeps the
  // port until its burst is used up.
  always_comb begin
    burst_open = (burst_cnt_q < BURST_LIMIT);
    grant      = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (burst_open) grant = (owner_q == 1'b1) ? 2'b10 : 2'b01;
        else            grant = (owner_q == 1'b1) ? 2'b01 : 2'b10;
      end
      default: grant = 2'b00;
    endcase
    grant_id = grant[1];
  end

  // Burst bookkeeping only moves on accepted beats, so idle cycles neither
  // count toward nor reset the burst.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (accept) begin
      if (grant_id == owner_q) begin
        if (burst_open) burst_cnt_d = burst_cnt_q + RAM_BURST_W'(1);
      end else begin
        owner_d     = grant_id;
        burst_cnt_d = RAM_BURST_W'(1);
      end
    end
  end

  // Owner and burst counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/ram_tdp_18k.sv
// True dual-port 18 Kb block RAM, single clock, unregistered output (one cycle
// read latency), NO_CHANGE write mode: the output holds during a write.
module ram_tdp_18k
  import ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RAM_ADDR_W,
  parameter int DATA_WIDTH    = RAM_DATA_W
) (
  input  logic                     clk,
  input  logic                     en_a,
  input  logic                     we_a,
  input  logic [ADDRESS_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0]    di_a,
  output logic [DATA_WIDTH-1:0]    dout_a,
  input  logic                     en_b,
  input  logic                     we_b,
  input  logic [ADDRESS_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0]    di_b,
  output logic [DATA_WIDTH-1:0]    dout_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  // Both ports in one process so the array has a single driver; port B wins a
  // same-address write collision.
  always_ff @(posedge clk) begin
    if (en_a) begin
      if (we_a) mem[addr_a] <= di_a;
      else      dout_a      <= mem[addr_a];
    end
    if (en_b) begin
      if (we_b) mem[addr_b] <= di_b;
      else      dout_b      <= mem[addr_b];
    end
  end

endmodule

// File: rtl/ram_tdp_port_arbiter.sv
// Shares one block RAM port between two valid/ready requesters and steers read
// data back to whichever requester issued the read.
module ram_tdp_port_arbiter
  import ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RAM_ADDR_W,
  parameter int DATA_WIDTH    = RAM_DATA_W,
  parameter int BURST_MAX     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_we,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_di,
  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_do,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_we,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_di,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_do,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_di,
  input  logic [DATA_WIDTH-1:0]    ram_do
);

  logic [1:0] grant;
  req_id_t    grant_id;
  logic       accept;
  logic       sel_we;
  logic       rd_pend_q, rd_pend_d;
  req_id_t    rd_id_q, rd_id_d;

  ram_arb_rr2 #(
    .BURST_MAX (BURST_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    ({req1_valid, req0_valid}),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Handshake and RAM drive; with no grant the mux rests on requester 0 so
  // the address/data pins never float.
  always_comb begin
    req0_ready = rst_n & grant[0];
    req1_ready = rst_n & grant[1];
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    sel_we     = grant[1] ? req1_we   : req0_we;
    ram_addr   = grant[1] ? req1_addr : req0_addr;
    ram_di     = grant[1] ? req1_di   : req0_di;
    ram_en     = accept;
    ram_we     = accept & sel_we;
  end

  // Remember an accepted read and its issuer for the cycle its data appears.
  always_comb begin
    rd_pend_d = accept & ~sel_we;
    rd_id_d   = grant_id;
  end

  // Read-return pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // Response steering; a response landing on a reset cycle is dropped.
  always_comb begin
    rsp0_valid = rst_n & rd_pend_q & (rd_id_q == 1'b0);
    rsp1_valid = rst_n & rd_pend_q & (rd_id_q == 1'b1);
    rsp0_do    = ram_do;
    rsp1_do    = ram_do;
  end

endmodule
